// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared framing definitions for the UART frame receiver and transmitter
package uart_frame_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GET_LEN     = 2'd1,
        GET_PAYLOAD = 2'd2,
        GET_CHK     = 2'd3
    } frame_state_t;

    localparam logic [1:0] ERR_PARITY  = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_rx_timeout.sv
// rtl/uart_frame_rx_timeout.sv - inter-byte stall counter for the frame receiver
module frame_timeout #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Count idle cycles inside a frame; any received byte or leaving the frame restarts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr || !run) begin
            count <= '0;
        end else if (count != TERMINAL) begin
            count <= count + CW'(1);
        end
    end

    assign expired = run && (count == TERMINAL);

endmodule

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - reassembles SOF/LEN/payload/checksum frames from received UART bytes
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN        = 8,
    parameter logic [7:0] SOF            = SOF_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 20000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           data_received,
    input  logic                 rx_done,
    input  logic                 parity_error,
    output logic [8*MAX_LEN-1:0] frame_data,
    output logic [7:0]           frame_len,
    output logic                 frame_valid,
    output logic                 frame_error,
    output logic [1:0]           error_code
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    frame_state_t         state, state_next;
    logic [7:0]           len, chk, idx;
    logic [8*MAX_LEN-1:0] shadow, shadow_masked;
    logic                 set_valid, set_error;
    logic [1:0]           err_next;
    logic                 expired, in_frame, byte_ok;

    assign in_frame = (state != IDLE);
    assign byte_ok  = rx_done && !parity_error;

    frame_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (rx_done),
        .run     (in_frame),
        .expired (expired)
    );

    // Frame state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and frame verdict; a received byte takes priority over a coincident timeout.
    always_comb begin
        state_next = state;
        set_valid  = 1'b0;
        set_error  = 1'b0;
        err_next   = error_code;
        if (rx_done) begin
            if (in_frame && parity_error) begin
                state_next = IDLE;
                set_error  = 1'b1;
                err_next   = ERR_PARITY;
            end else begin
                case (state)
                    IDLE: begin
                        if (!parity_error && data_received == SOF) begin
                            state_next = GET_LEN;
                        end
                    end
                    GET_LEN: begin
                        if (data_received == 8'd0 || data_received > MAX_LEN_B) begin
                            state_next = IDLE;
                            set_error  = 1'b1;
                            err_next   = ERR_LEN;
                        end else begin
                            state_next = GET_PAYLOAD;
                        end
                    end
                    GET_PAYLOAD: begin
                        if (idx == len - 8'd1) begin
                            state_next = GET_CHK;
                        end
                    end
                    GET_CHK: begin
                        state_next = IDLE;
                        if (data_received == chk) begin
                            set_valid = 1'b1;
                        end else begin
                            set_error = 1'b1;
                            err_next  = ERR_CHK;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end else if (expired) begin
            state_next = IDLE;
            set_error  = 1'b1;
            err_next   = ERR_TIMEOUT;
        end
    end

    // Length latch, running checksum and payload capture into the shadow buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len    <= '0;
            chk    <= '0;
            idx    <= '0;
            shadow <= '0;
        end else if (byte_ok) begin
            if (state == GET_LEN && state_next == GET_PAYLOAD) begin
                len <= data_received;
                chk <= data_received;
                idx <= '0;
            end else if (state == GET_PAYLOAD) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (idx == 8'(i)) begin
                        shadow[8*i +: 8] <= data_received;
                    end
                end
                chk <= chk ^ data_received;
                idx <= idx + 8'd1;
            end
        end
    end

    // Bytes beyond the current length may hold a longer earlier frame, so they are zeroed on publish.
    always_comb begin
        shadow_masked = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (8'(i) < len) begin
                shadow_masked[8*i +: 8] = shadow[8*i +: 8];
            end
        end
    end

    // Registered result strobes and the published frame, which only a good checksum may update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_data  <= '0;
            frame_len   <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            error_code  <= ERR_PARITY;
        end else begin
            frame_valid <= set_valid;
            frame_error <= set_error;
            if (set_error) begin
                error_code <= err_next;
            end
            if (set_valid) begin
                frame_data <= shadow_masked;
                frame_len  <= len;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - randomized self-checking bench for uart_frame_rx
module tb_uart_frame_rx;
    import uart_frame_pkg::*;

    localparam int         MAX_LEN = 8;
    localparam int         TC      = 40;
    localparam logic [7:0] SOFB    = 8'hA5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [7:0]           data_received;
    logic                 rx_done;
    logic                 parity_error;
    logic [8*MAX_LEN-1:0] frame_data;
    logic [7:0]           frame_len;
    logic                 frame_valid;
    logic                 frame_error;
    logic [1:0]           error_code;

    always #5 clk = ~clk;

    uart_frame_rx #(
        .MAX_LEN        (MAX_LEN),
        .SOF            (SOFB),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_received (data_received),
        .rx_done       (rx_done),
        .parity_error  (parity_error),
        .frame_data    (frame_data),
        .frame_len     (frame_len),
        .frame_valid   (frame_valid),
        .frame_error   (frame_error),
        .error_code    (error_code)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: the frame seen so far is a queue of bytes after SOF.
    bit          m_in_frame;
    bit          m_have_len;
    int          m_len;
    logic [7:0]  m_pay[$];
    logic [63:0] m_data;
    logic [7:0]  m_flen;
    logic [1:0]  m_code;
    int          m_idle;

    task automatic model_reset();
        m_in_frame = 0;
        m_have_len = 0;
        m_pay.delete();
        m_data = '0;
        m_flen = '0;
        m_code = ERR_PARITY;
        m_idle = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit p, output bit v, output bit e);
        logic [7:0] x;
        v = 0;
        e = 0;
        m_idle = 0;
        if (!m_in_frame) begin
            if (!p && b == SOFB) begin
                m_in_frame = 1;
                m_have_len = 0;
                m_pay.delete();
            end
        end else if (p) begin
            e = 1; m_code = ERR_PARITY; m_in_frame = 0;
        end else if (!m_have_len) begin
            if (b == 8'd0 || int'(b) > MAX_LEN) begin
                e = 1; m_code = ERR_LEN; m_in_frame = 0;
            end else begin
                m_have_len = 1;
                m_len = int'(b);
            end
        end else if (m_pay.size() < m_len) begin
            m_pay.push_back(b);
        end else begin
            x = 8'(m_len);
            foreach (m_pay[i]) x = x ^ m_pay[i];
            if (b == x) begin
                v = 1;
                m_flen = 8'(m_len);
                m_data = '0;
                foreach (m_pay[i]) m_data[8*i +: 8] = m_pay[i];
            end else begin
                e = 1; m_code = ERR_CHK;
            end
            m_in_frame = 0;
        end
    endtask

    task automatic model_idle(output bit v, output bit e);
        v = 0;
        e = 0;
        m_idle++;
        if (m_in_frame && m_idle == TC) begin
            e = 1; m_code = ERR_TIMEOUT; m_in_frame = 0;
        end
    endtask

    task automatic check_outputs(input bit ev, input bit ee);
        check("frame_valid", 64'(frame_valid), 64'(ev));
        check("frame_error", 64'(frame_error), 64'(ee));
        check("error_code",  64'(error_code),  64'(m_code));
        check("frame_len",   64'(frame_len),   64'(m_flen));
        check("frame_data",  frame_data,       m_data);
    endtask

    // Called on a negedge: present one byte for one cycle, then idle for gap cycles.
    task automatic send(input logic [7:0] b, input bit p, input int gap);
        bit v, e;
        data_received = b;
        parity_error  = p;
        rx_done       = 1'b1;
        @(negedge clk);
        rx_done       = 1'b0;
        parity_error  = 1'b0;
        data_received = 8'($urandom);
        model_byte(b, p, v, e);
        check_outputs(v, e);
        for (int j = 0; j < gap; j++) begin
            @(negedge clk);
            model_idle(v, e);
            check_outputs(v, e);
        end
    endtask

    task automatic send_seq(input logic [7:0] q[$], input int gap);
        foreach (q[i]) send(q[i], 1'b0, gap);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        check("rst_valid", 64'(frame_valid), 64'd0);
        check("rst_error", 64'(frame_error), 64'd0);
        check("rst_code",  64'(error_code),  64'd0);
        check("rst_len",   64'(frame_len),   64'd0);
        check("rst_data",  frame_data,       64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_outputs(0, 0);
    endtask

    task automatic rand_frame();
        logic [7:0] fb[$];
        logic [7:0] c;
        int kind, len, k;
        kind = $urandom_range(0, 9);
        len  = $urandom_range(1, MAX_LEN);
        c    = 8'(len);
        fb.push_back(SOFB);
        fb.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            fb.push_back(8'($urandom));
            c = c ^ fb[i+2];
        end
        fb.push_back(c);
        case (kind)
            5: begin
                fb[fb.size()-1] = c ^ 8'($urandom_range(1, 255));
                foreach (fb[i]) send(fb[i], 1'b0, $urandom_range(0, 3));
            end
            6: begin
                send(SOFB, 1'b0, $urandom_range(0, 3));
                send(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)),
                     1'b0, $urandom_range(0, 3));
            end
            7: begin
                k = $urandom_range(1, fb.size() - 1);
                for (int i = 0; i < k; i++) send(fb[i], 1'b0, $urandom_range(0, 3));
                send(fb[k], 1'b1, $urandom_range(0, 3));
            end
            8: begin
                k = $urandom_range(1, fb.size() - 1);
                for (int i = 0; i < k - 1; i++) send(fb[i], 1'b0, $urandom_range(0, 3));
                send(fb[k-1], 1'b0, TC + $urandom_range(0, 2));
            end
            9: begin
                send(SOFB, 1'b1, $urandom_range(0, 3));
                c = 8'($urandom);
                if (c == SOFB) c = 8'h00;
                send(c, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            end
            default: begin
                foreach (fb[i]) send(fb[i], 1'b0, $urandom_range(0, 3));
            end
        endcase
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        rx_done       = 1'b0;
        parity_error  = 1'b0;
        data_received = 8'h00;
        model_reset();
        #1;
        check_outputs(0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_outputs(0, 0);

        send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}, 1);
        check("tp_good_data", frame_data, 64'h0000_0000_0033_2211);
        check("tp_good_len", 64'(frame_len), 64'd3);
        send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04}, 0);
        check("tp_chk_code", 64'(error_code), 64'd2);
        check("tp_chk_keep", frame_data, 64'h0000_0000_0033_2211);
        send_seq('{8'hA5, 8'h09}, 2);
        check("tp_len9_code", 64'(error_code), 64'd1);
        send(8'h00, 1'b0, 0);
        send_seq('{8'hA5, 8'h00}, 1);
        check("tp_len0_code", 64'(error_code), 64'd1);
        send_seq('{8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h7F}, 0);
        check("tp_one_data", frame_data, 64'h7E);
        send_seq('{8'hA5, 8'h02}, 1);
        send(8'h11, 1'b0, TC);
        check("tp_timeout_code", 64'(error_code), 64'd3);
        send_seq('{8'hA5, 8'h02, 8'h11, 8'h22, 8'h31}, 1);
        check("tp_after_to_len", 64'(frame_len), 64'd2);
        send_seq('{8'hA5, 8'h02, 8'h11}, 1);
        send(8'h22, 1'b1, 1);
        check("tp_parity_code", 64'(error_code), 64'd0);
        send_seq('{8'hA5, 8'h03, 8'h11, 8'h22}, 1);
        pulse_reset();
        send_seq('{8'hA5, 8'h01, 8'h5C, 8'h5D}, 0);
        check("tp_post_reset", frame_data, 64'h5C);

        for (int n = 0; n < 240; n++) begin
            rand_frame();
            if (n % 60 == 59) pulse_reset();
        end
        for (int j = 0; j < TC + 2; j++) begin
            bit v, e;
            @(negedge clk);
            model_idle(v, e);
            check_outputs(v, e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
